rej_sampler_stream: RTL and testbench
=====================================

# rej_sampler_stream

Streaming, multi-mode rejection sampler: the parametrised successor of the fixed-seed NTT-polynomial sampler. It consumes a SHAKE output byte stream over a valid/ready interface and emits exactly N accepted coefficients over a second valid/ready interface. Coefficients are in Z_q form. Supports uniform sampling for ExpandA (RejNTTPoly) and bounded sampling with eta = 2 or eta = 4 for ExpandS (RejBoundedPoly). It sits between the Keccak squeeze port and the NTT / polynomial RAM, so one instance serves both matrix and secret-vector generation.

## Interface
- N, 256, coefficients per polynomial
- COEFF_WIDTH, 24, output coefficient width (≥ 23)
- DATA_IN_BITS, 64, input word width; must be a multiple of 8 and ≥ 24
- Q, 8380417, modulus
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- mode  in  2  sampling mode, latched at start: 0 = uniform, 1 = eta 2, 2 = eta 4, 3 = reserved
- in_data  in  DATA_IN_BITS  XOF bytes; byte 0 = bits [7:0] = earliest in stream
- in_valid  in  1  in_data valid
- in_ready  out  1  sampler can accept one word this cycle
- out_coeff  out  COEFF_WIDTH  accepted coefficient, zero-extended, range [0, Q-1]
- out_idx  out  $clog2(N)  index of out_coeff within the polynomial
- out_valid  out  1  out_coeff/out_idx valid
- out_ready  in  1  downstream accepts
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the N-th output handshake

## Operation
- **States:**
  - IDLE: start with mode≠3 latches mode, clears count and buffer, then moves to RUN. start with mode=3 is ignored.
  - RUN: moves to DONE when the N-th out handshake occurs.
  - DONE: one cycle, done=1, then returns to IDLE.
- **Bit buffer:** 2*DATA_IN_BITS bits with a fill counter in bits. Data is consumed from the LSB end and new words are appended above the current fill.
  - in_ready = RUN && fill ≤ DATA_IN_BITS.
  - A word is accepted on in_valid && in_ready.
  - A load and a consume in the same cycle are legal: fill_next = fill − consumed + DATA_IN_BITS.
- **Candidate step:** at most one per cycle. It runs only when RUN, the output register is free or draining (!out_valid || out_ready), and fill ≥ step size.
- **Mode 0 (uniform):**
  - Step size is 24 bits: t = {b2[6:0], b1, b0}, so bit 23 is masked.
  - Accept iff t < Q. out_coeff = t.
- **Mode 1 (eta 2):**
  - Step size is 4 bits (one nibble); the low nibble of a byte is taken before the high nibble.
  - Accept iff z < 15. Coefficient c = 2 − (z mod 5).
- **Mode 2 (eta 4):**
  - Step size is 4 bits. Accept iff z < 9. Coefficient c = 4 − z.
- **Bounded-mode mapping:** negative c maps to Q + c, non-negative c maps to c. Modular reduction uses a compare/subtract chain, never a divider.
- **Rejects:** a rejected candidate consumes its bits and produces no output.
- **Output index:** out_idx = the number of coefficients already accepted. The count increments only on the out handshake.
- **End of polynomial:** after the N-th handshake, the residual buffer is discarded, in_ready drops, and no further candidates are evaluated.
- **Input overrun:** excess XOF data beyond what is needed is never consumed. The upstream is expected to be reset or re-seeded by the controller.

## Timing
- **Reset values:** in_ready=0, out_valid=0, out_coeff=0, out_idx=0, busy=0, done=0. State=IDLE, fill=0.
- **Start:** start sampled at edge k gives busy=1 and in_ready=1 after edge k.
- **Input-to-output latency:** a word accepted at edge m makes its first candidate evaluated in cycle m+1. If that candidate is accepted, out_valid=1 after edge m+1.
- **Throughput:** one candidate per cycle sustained with out_ready=1.
  - Mode 0: one 64-bit word feeds 2⅔ candidates.
  - Modes 1/2: one 64-bit word feeds 16 candidates.
- **Backpressure:** with out_valid && !out_ready, out_coeff and out_idx hold stable and candidate evaluation stalls. Input may still load while fill ≤ DATA_IN_BITS.
- **Done timing:** the N-th handshake at edge p gives done=1 and busy=0 in cycle p+1, and IDLE at edge p+2. out_valid is 0 from edge p on.
- **Start while busy:** ignored; the latched mode does not change.
- **Mid-operation reset:** asynchronous assertion immediately forces all reset values. Buffer contents are lost and no partial done is produced.

## Test plan
- **Mode 0 accept/reject boundaries:** byte stream 01 00 00 | FF FF FF | 00 E0 7F | 01 E0 7F | 05 00 80 → outputs 1 (idx 0), 8380416 (idx 1), 5 (idx 2). 0x7FFFFF and Q itself are rejected; bit 23 of the last triple is masked.
- **Mode 1:** bytes F0 31 → outputs 2, 1, 8380416. Nibble 15 is rejected.
- **Mode 2:** bytes 98 40 → outputs 8380413, 4, 0. Nibble 9 is rejected.
- **Full polynomial, mode 0, random seed stream:** exactly 256 handshakes with out_idx 0..255. done is one cycle after the last handshake. Coefficients match the golden FIPS 204 model.
- **Random backpressure:** out_ready at 30% duty and in_valid gaps → identical coefficient sequence to the unstalled run. out_coeff is stable whenever out_valid && !out_ready.
- **Reset and protocol corners:**
  - rst asserted at output 100 → all outputs drop asynchronously.
  - After release, start in mode 1 → a fresh sequence beginning at idx 0.
  - start with mode=3 → busy stays 0.

Source files
------------

// File: rtl/rej_sampler_stream_if.sv
// rej_sampler_stream_if: XOF byte-stream input and coefficient output handshakes of the rejection sampler.
interface rej_sampler_stream_if #(
   parameter int DATA_IN_BITS = 64,
   parameter int COEFF_WIDTH = 24,
   parameter int N = 256
);
   logic [DATA_IN_BITS-1:0] in_data;
   logic in_valid;
   logic in_ready;
   logic [COEFF_WIDTH-1:0] out_coeff;
   logic [$clog2(N)-1:0] out_idx;
   logic out_valid;
   logic out_ready;
   modport master(output in_data, in_valid, out_ready, input in_ready, out_coeff, out_idx, out_valid);
   modport slave(input in_data, in_valid, out_ready, output in_ready, out_coeff, out_idx, out_valid);
endinterface

// File: rtl/rej_sampler_stream.sv
// rej_sampler_stream: streaming rejection sampler producing N coefficients in Z_q
// from an XOF byte stream, uniform (24-bit) or bounded eta 2 / eta 4 (nibble) modes.
module rej_sampler_stream #(
   parameter int N = 256,
   parameter int COEFF_WIDTH = 24,
   parameter int DATA_IN_BITS = 64,
   parameter int Q = 8380417
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic [1:0] mode,
   output logic busy,
   output logic done,
   rej_sampler_stream_if.slave st
);
   localparam int IW = $clog2(N);
   localparam int BW = 2 * DATA_IN_BITS;
   localparam int FW = $clog2(BW + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [BW-1:0] sbuf;
   logic [FW-1:0] fill, step, cons;
   logic [1:0] mode_q;
   logic [IW:0] count;
   logic [23:0] t;
   logic [3:0] z, zm, mag;
   logic go, hs, last, load, eval, acc, neg;
   logic [COEFF_WIDTH-1:0] coeff;
   assign go = start && mode != 2'd3;
   assign hs = st.out_valid && st.out_ready;
   assign last = hs && count == (IW+1)'(N - 1);
   assign st.in_ready = state == RUN && fill <= FW'(DATA_IN_BITS);
   assign load = st.in_valid && st.in_ready;
   assign st.out_idx = count[IW-1:0];
   assign busy = state == RUN;
   assign done = state == DONE;
   always_comb begin
      state_n = state == IDLE ? (go ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
      step = mode_q == 2'd0 ? FW'(24) : FW'(4);
      eval = state == RUN && (!st.out_valid || st.out_ready) && fill >= step && !last;
      cons = eval ? step : '0;
      t = {1'b0, sbuf[22:0]};
      z = sbuf[3:0];
      zm = z >= 4'd10 ? z - 4'd10 : z >= 4'd5 ? z - 4'd5 : z;
      // bounded modes: c = centre - v, carried as sign + magnitude so Q + c is one subtract
      neg = mode_q == 2'd1 ? zm > 4'd2 : z > 4'd4;
      mag = mode_q == 2'd1 ? (neg ? zm - 4'd2 : 4'd2 - zm) : (neg ? z - 4'd4 : 4'd4 - z);
      acc = mode_q == 2'd0 ? t < 24'(Q) : mode_q == 2'd1 ? z < 4'd15 : z < 4'd9;
      coeff = mode_q == 2'd0 ? COEFF_WIDTH'(t) :
              neg ? COEFF_WIDTH'(Q) - COEFF_WIDTH'(mag) : COEFF_WIDTH'(mag);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sbuf <= '0;
         fill <= '0;
         mode_q <= '0;
         count <= '0;
         st.out_valid <= 1'b0;
         st.out_coeff <= '0;
      end else if (state == IDLE && go) begin
         mode_q <= mode;
         count <= '0;
         sbuf <= '0;
         fill <= '0;
         st.out_valid <= 1'b0;
      end else if (last) begin
         count <= count + 1'b1;
         st.out_valid <= 1'b0;
         sbuf <= '0;
         fill <= '0;
      end else begin
         // bits above fill are always zero, so a new word is simply OR-ed in above the residue
         sbuf <= (sbuf >> cons) | (load ? BW'(st.in_data) << (fill - cons) : '0);
         fill <= fill - cons + (load ? FW'(DATA_IN_BITS) : FW'(0));
         if (hs) count <= count + 1'b1;
         if (hs || eval) st.out_valid <= eval && acc;
         if (eval && acc) st.out_coeff <= coeff;
      end
   end
endmodule

// File: tb/tb_rej_sampler_stream.sv
// tb_rej_sampler_stream: randomized self-checking bench; expected coefficients come from a
// byte-level model of the rejection rules applied to the same XOF stream fed to the sampler.
module tb_rej_sampler_stream;
   localparam int N = 256;
   localparam int Q = 8380417;
   logic clk = 0, rst_n = 0, start = 0, busy, done;
   logic [1:0] mode = 0;
   rej_sampler_stream_if bus();
   rej_sampler_stream dut(.clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done), .st(bus));
   always #5 clk = ~clk;
   bit [7:0] bytes[$];
   logic [63:0] words[$];
   int exp_c[$];
   logic [23:0] got_c[$], ref_c[$];
   logic [7:0] got_i[$];
   int unstable, errors = 0, checks = 0;
   logic timeout, d1, b1, v1, r1, d2;

   function automatic void model(input logic [1:0] m);
      int p = 0, t, z, c;
      exp_c.delete();
      while (exp_c.size() < N) begin
         if (m == 0) begin
            if (p + 3 > bytes.size()) break;
            t = int'(bytes[p]) + int'(bytes[p+1]) * 256 + (int'(bytes[p+2]) % 128) * 65536;
            p += 3;
            if (t < Q) exp_c.push_back(t);
         end else begin
            if (p / 2 >= bytes.size()) break;
            z = p % 2 == 0 ? int'(bytes[p/2]) % 16 : int'(bytes[p/2]) / 16;
            p++;
            c = m == 1 ? 2 - z % 5 : 4 - z;
            if ((m == 1 && z < 15) || (m == 2 && z < 9)) exp_c.push_back(c < 0 ? Q + c : c);
         end
      end
   endfunction

   task automatic prep(input int nwords);
      logic [63:0] w;
      while (bytes.size() < 8 * nwords) bytes.push_back(8'($urandom));
      words.delete();
      for (int i = 0; i < nwords; i++) begin
         for (int j = 0; j < 8; j++) w[8*j +: 8] = bytes[8*i+j];
         words.push_back(w);
      end
   endtask

   task automatic run(input logic [1:0] m, input int in_pct, input int out_pct, input int stop_at);
      int wi = 0, cyc = 0;
      logic stall = 0;
      logic [23:0] pc = 0;
      logic [7:0] pi = 0;
      got_c.delete();
      got_i.delete();
      unstable = 0;
      timeout = 0;
      @(negedge clk);
      start = 1;
      mode = m;
      @(negedge clk);
      start = 0;
      while (got_c.size() < stop_at && !timeout) begin
         bus.in_valid = wi < words.size() && $urandom_range(99) < in_pct;
         bus.in_data = wi < words.size() ? words[wi] : '0;
         bus.out_ready = $urandom_range(99) < out_pct;
         #1;
         if (stall && (bus.out_valid !== 1'b1 || bus.out_coeff !== pc || bus.out_idx !== pi)) unstable++;
         stall = bus.out_valid && !bus.out_ready;
         pc = bus.out_coeff;
         pi = bus.out_idx;
         if (bus.in_valid && bus.in_ready) wi++;
         if (bus.out_valid && bus.out_ready) begin
            got_c.push_back(bus.out_coeff);
            got_i.push_back(bus.out_idx);
         end
         @(negedge clk);
         cyc++;
         timeout = cyc > 5000;
      end
      bus.in_valid = 0;
      bus.out_ready = 0;
      #1;
      d1 = done; b1 = busy; v1 = bus.out_valid; r1 = bus.in_ready;
      @(negedge clk);
      #1;
      d2 = done;
   endtask

   task automatic test_reset;
      bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid, busy, done, bus.out_coeff, bus.out_idx} !== '0) begin
         errors++;
         $display("FAIL reset_values got rdy=%b v=%b busy=%b done=%b c=%0d i=%0d exp all 0",
                  bus.in_ready, bus.out_valid, busy, done, bus.out_coeff, bus.out_idx);
      end
      rst_n = 1;
   endtask

   task automatic test_mode0_bounds;
      int lit[3] = '{1, 8380416, 5};
      bytes = {8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hE0, 8'h7F, 8'h01, 8'hE0, 8'h7F, 8'h05, 8'h00, 8'h80};
      prep(120);
      model(0);
      run(0, 100, 100, N);
      checks++;
      if (timeout || got_c.size() != N) begin errors++; $display("FAIL m0b_count got %0d exp %0d", got_c.size(), N); end
      for (int i = 0; i < 3 && i < got_c.size(); i++) begin
         checks++;
         if (got_c[i] !== 24'(lit[i]) || got_i[i] !== 8'(i)) begin
            errors++; $display("FAIL m0b_lit[%0d] got %0d@%0d exp %0d@%0d", i, got_c[i], got_i[i], lit[i], i);
         end
      end
      for (int i = 0; i < got_c.size(); i++) begin
         checks++;
         if (i >= exp_c.size() || got_c[i] !== 24'(exp_c[i]) || got_i[i] !== 8'(i)) begin
            errors++; $display("FAIL m0b_coeff[%0d] got %0d@%0d exp %0d@%0d", i, got_c[i], got_i[i], exp_c[i], i);
         end
      end
   endtask

   task automatic test_mode1;
      int lit[3] = '{2, 1, 8380416};
      bytes = {8'hF0, 8'h31};
      prep(40);
      model(1);
      run(1, 100, 100, N);
      checks++;
      if (timeout || got_c.size() != N) begin errors++; $display("FAIL m1_count got %0d exp %0d", got_c.size(), N); end
      for (int i = 0; i < 3 && i < got_c.size(); i++) begin
         checks++;
         if (got_c[i] !== 24'(lit[i])) begin errors++; $display("FAIL m1_lit[%0d] got %0d exp %0d", i, got_c[i], lit[i]); end
      end
      for (int i = 0; i < got_c.size(); i++) begin
         checks++;
         if (i >= exp_c.size() || got_c[i] !== 24'(exp_c[i]) || got_i[i] !== 8'(i)) begin
            errors++; $display("FAIL m1_coeff[%0d] got %0d@%0d exp %0d@%0d", i, got_c[i], got_i[i], exp_c[i], i);
         end
      end
   endtask

   task automatic test_mode2;
      int lit[3] = '{8380413, 4, 0};
      bytes = {8'h98, 8'h40};
      prep(60);
      model(2);
      run(2, 100, 100, N);
      checks++;
      if (timeout || got_c.size() != N) begin errors++; $display("FAIL m2_count got %0d exp %0d", got_c.size(), N); end
      for (int i = 0; i < 3 && i < got_c.size(); i++) begin
         checks++;
         if (got_c[i] !== 24'(lit[i])) begin errors++; $display("FAIL m2_lit[%0d] got %0d exp %0d", i, got_c[i], lit[i]); end
      end
      for (int i = 0; i < got_c.size(); i++) begin
         checks++;
         if (i >= exp_c.size() || got_c[i] !== 24'(exp_c[i]) || got_i[i] !== 8'(i)) begin
            errors++; $display("FAIL m2_coeff[%0d] got %0d@%0d exp %0d@%0d", i, got_c[i], got_i[i], exp_c[i], i);
         end
      end
   endtask

   task automatic test_full_poly;
      bytes.delete();
      prep(120);
      model(0);
      run(0, 100, 100, N);
      checks++;
      if (timeout || got_c.size() != N) begin errors++; $display("FAIL full_count got %0d exp %0d", got_c.size(), N); end
      for (int i = 0; i < got_c.size(); i++) begin
         checks++;
         if (i >= exp_c.size() || got_c[i] !== 24'(exp_c[i]) || got_i[i] !== 8'(i)) begin
            errors++; $display("FAIL full_coeff[%0d] got %0d@%0d exp %0d@%0d", i, got_c[i], got_i[i], exp_c[i], i);
         end
      end
      checks++;
      if ({d1, b1, v1, r1, d2} !== 5'b10000) begin
         errors++; $display("FAIL full_done_timing got done=%b busy=%b v=%b rdy=%b done_next=%b exp 1 0 0 0 0", d1, b1, v1, r1, d2);
      end
   endtask

   task automatic test_backpressure;
      bytes.delete();
      prep(120);
      model(0);
      run(0, 100, 100, N);
      ref_c = got_c;
      run(0, 70, 30, N);
      checks++;
      if (timeout || got_c.size() != N) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_c.size(), N); end
      for (int i = 0; i < got_c.size(); i++) begin
         checks++;
         if (i >= ref_c.size() || got_c[i] !== ref_c[i] || got_c[i] !== 24'(exp_c[i]) || got_i[i] !== 8'(i)) begin
            errors++; $display("FAIL bp_coeff[%0d] got %0d@%0d exp %0d@%0d", i, got_c[i], got_i[i], exp_c[i], i);
         end
      end
      checks++;
      if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
      checks++;
      if (d1 !== 1'b1 || d2 !== 1'b0) begin errors++; $display("FAIL bp_done got %b%b exp 10", d1, d2); end
   endtask

   task automatic test_mode3;
      @(negedge clk);
      start = 1;
      mode = 3;
      @(negedge clk);
      start = 0;
      #1;
      checks++;
      if ({busy, bus.in_ready, done} !== 3'b000) begin
         errors++; $display("FAIL mode3_ignored got busy=%b rdy=%b done=%b exp 0 0 0", busy, bus.in_ready, done);
      end
   endtask

   task automatic test_reset_mid;
      bytes.delete();
      prep(120);
      model(0);
      run(0, 100, 100, 100);
      checks++;
      if (timeout || got_c.size() != 100 || b1 !== 1'b1) begin
         errors++; $display("FAIL mid_prefix got %0d outputs busy=%b exp 100 busy=1", got_c.size(), b1);
      end
      for (int i = 0; i < got_c.size(); i++) begin
         checks++;
         if (got_c[i] !== 24'(exp_c[i]) || got_i[i] !== 8'(i)) begin
            errors++; $display("FAIL mid_coeff[%0d] got %0d@%0d exp %0d@%0d", i, got_c[i], got_i[i], exp_c[i], i);
         end
      end
      rst_n = 0;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, busy, done, bus.out_coeff, bus.out_idx} !== '0) begin
         errors++;
         $display("FAIL mid_async_reset got rdy=%b v=%b busy=%b done=%b c=%0d i=%0d exp all 0",
                  bus.in_ready, bus.out_valid, busy, done, bus.out_coeff, bus.out_idx);
      end
      @(negedge clk);
      rst_n = 1;
      bytes.delete();
      prep(40);
      model(1);
      run(1, 100, 100, N);
      checks++;
      if (timeout || got_c.size() != N) begin errors++; $display("FAIL post_count got %0d exp %0d", got_c.size(), N); end
      for (int i = 0; i < got_c.size(); i++) begin
         checks++;
         if (i >= exp_c.size() || got_c[i] !== 24'(exp_c[i]) || got_i[i] !== 8'(i)) begin
            errors++; $display("FAIL post_coeff[%0d] got %0d@%0d exp %0d@%0d", i, got_c[i], got_i[i], exp_c[i], i);
         end
      end
   endtask

   initial begin
      test_reset;
      test_mode0_bounds;
      test_mode1;
      test_mode2;
      test_full_poly;
      test_backpressure;
      test_mode3;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
